// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM state type, round-constant
// seed, field polynomial, round limit and the GF(2^8) doubling helper.
package aes_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ks_state_e;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] GF_POLY    = 8'h1B;
  localparam int         MAX_ROUNDS = 10;

  // Multiply by x in GF(2^8): shift left, reduce on bit-7 overflow.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_subword.sv
// subWord: 32-bit combinational AES S-box substitution (four byte lookups).
module subWord (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  // Forward S-box, index 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte-wise table lookup.
  always_comb begin
    word_o[31:24] = SBOX[word_i[31:24]];
    word_o[23:16] = SBOX[word_i[23:16]];
    word_o[15:8]  = SBOX[word_i[15:8]];
    word_o[7:0]   = SBOX[word_i[7:0]];
  end

endmodule

// File: rtl/key_schedule.sv
// key_schedule: AES-128 round-key generator with a valid/ready output.
// Emits round key 0 (the cipher key) followed by NUM_ROUNDS derived keys,
// one per accepted handshake. Optional macro KEY_SCHEDULE_KEYBUF_EN adds an
// 11-entry round-key buffer with a registered read port (rd_idx/rd_key).
module key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
`ifdef KEY_SCHEDULE_KEYBUF_EN
  output logic         done,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`else
  output logic         done
`endif
);

  ks_state_e    state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic         hs;
  logic         last;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w4, w5, w6, w7;
  logic [31:0]  sub_w, t_w;
  logic [127:0] next_key;

  assign hs   = (state_q == ST_EMIT) && rk_ready;
  assign last = (round_q == 4'(NUM_ROUNDS));

  assign {w0, w1, w2, w3} = rk_q;

  // RotWord is a byte rotate left of w3 ahead of the S-box.
  subWord u_subword (
    .word_i ({w3[23:0], w3[31:24]}),
    .word_o (sub_w)
  );

  assign t_w      = sub_w ^ {rcon_q, 24'h0};
  assign w4       = w0 ^ t_w;
  assign w5       = w1 ^ w4;
  assign w6       = w2 ^ w5;
  assign w7       = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state: start only matters in IDLE, last handshake ends EMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_EMIT;
      ST_EMIT: if (hs && last) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: valid and busy are both just "in EMIT".
  always_comb begin
    busy     = (state_q == ST_EMIT);
    rk_valid = (state_q == ST_EMIT);
  end

  // Datapath next values: load on start, expand on each non-final handshake.
  always_comb begin
    rk_d    = rk_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        rk_d    = key;
        round_d = 4'd0;
        rcon_d  = RCON_INIT;
      end
    end else if (hs) begin
      if (last) begin
        done_d = 1'b1;
      end else begin
        rk_d    = next_key;
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_q    <= 128'h0;
      round_q <= 4'd0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign rk       = rk_q;
  assign rk_round = round_q;
  assign done     = done_q;

`ifdef KEY_SCHEDULE_KEYBUF_EN
  logic [127:0] keybuf_q [0:MAX_ROUNDS];
  logic [127:0] rd_key_q;

  // Capture every presented round key at its round index (no reset).
  always_ff @(posedge clk) begin
    if (rk_valid && (round_q <= 4'(MAX_ROUNDS))) keybuf_q[round_q] <= rk_q;
  end

  // Registered read; indices beyond the last round read as zero.
  always_ff @(posedge clk) begin
    if (rd_idx <= 4'(MAX_ROUNDS)) rd_key_q <= keybuf_q[rd_idx];
    else                          rd_key_q <= 128'h0;
  end

  assign rd_key = rd_key_q;
`endif

endmodule

// File: tb/tb_key_schedule.sv
// Directed testbench for key_schedule (FIPS-197 A.1 and all-zero key).
module tb_key_schedule;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;
`ifdef KEY_SCHEDULE_KEYBUF_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  logic [127:0] fips_rk [0:10];

  typedef struct {
    string        name;
    logic [127:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [0:12];

  key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .key      (key),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_round (rk_round),
    .busy     (busy),
`ifdef KEY_SCHEDULE_KEYBUF_EN
    .done     (done),
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
`else
    .done     (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rk_ready = 1'b1;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("drain_timeout_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    for (int i = 0; i <= 10; i++)
      vecs[i] = '{name: "fips", key: FIPS_KEY, round: i, exp: fips_rk[i]};
    vecs[11] = '{name: "zero", key: 128'h0, round: 0, exp: 128'h0};
    vecs[12] = '{name: "zero", key: 128'h0, round: 1, exp: ZERO_R1};

    reset_n  = 1'b1;
    start    = 1'b0;
    key      = 128'h0;
    rk_ready = 1'b1;
`ifdef KEY_SCHEDULE_KEYBUF_EN
    rd_idx   = 4'd0;
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("reset_rk_valid", 128'(rk_valid), 128'(0));
    chk("reset_rk", rk, 128'h0);
    chk("reset_rk_round", 128'(rk_round), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    step();
    step();
    reset_n = 1'b1;
    step();

    // Table-driven pass under continuous ready.
    for (int i = 0; i <= 12; i++) begin
      if (vecs[i].round == 0) begin
        drain();
        do_start(vecs[i].key);
      end else begin
        rk_ready = 1'b1;
        step();
      end
      chk({vecs[i].name, "_rk"}, rk, vecs[i].exp);
      chk({vecs[i].name, "_round"}, 128'(rk_round), 128'(vecs[i].round));
      chk({vecs[i].name, "_valid"}, 128'(rk_valid), 128'(1));
    end
    drain();

    // Continuous run with a start pulse at round 4, then restart in done cycle.
    do_start(FIPS_KEY);
    for (int r = 0; r <= 10; r++) begin
      chk("cont_rk", rk, fips_rk[r]);
      chk("cont_round", 128'(rk_round), 128'(r));
      chk("cont_valid", 128'(rk_valid), 128'(1));
      chk("cont_done_low", 128'(done), 128'(0));
      if (r == 4) begin
        start = 1'b1;
        key   = 128'h0;
      end
      step();
      start = 1'b0;
      key   = FIPS_KEY;
    end
    chk("end_done", 128'(done), 128'(1));
    chk("end_valid", 128'(rk_valid), 128'(0));
    chk("end_busy", 128'(busy), 128'(0));
    chk("end_rk_hold", rk, fips_rk[10]);
    do_start(128'h0);
    chk("restart_done_low", 128'(done), 128'(0));
    chk("restart_valid", 128'(rk_valid), 128'(1));
    chk("restart_round", 128'(rk_round), 128'(0));
    chk("restart_rk", rk, 128'h0);
    step();
    chk("restart_rk_r1", rk, ZERO_R1);
    drain();

    // Pseudo-random ready stalls: keys must hold and arrive in order.
    begin
      int r;
      int cyc;
      logic rdy;
      r   = 0;
      cyc = 0;
      do_start(FIPS_KEY);
      while (r <= 10 && cyc < 300) begin
        chk("stall_valid", 128'(rk_valid), 128'(1));
        chk("stall_rk", rk, fips_rk[r]);
        chk("stall_round", 128'(rk_round), 128'(r));
        rdy      = 1'($urandom_range(0, 1));
        rk_ready = rdy;
        step();
        cyc++;
        if (rdy) r++;
      end
      chk("stall_timeout_round", 128'(r), 128'(11));
      chk("stall_done", 128'(done), 128'(1));
      rk_ready = 1'b1;
      step();
      chk("stall_done_pulse_end", 128'(done), 128'(0));
    end

`ifdef KEY_SCHEDULE_KEYBUF_EN
    rd_idx = 4'd10;
    step();
    chk("keybuf_rd10", rd_key, fips_rk[10]);
    rd_idx = 4'd3;
    step();
    chk("keybuf_rd3", rd_key, fips_rk[3]);
    rd_idx = 4'd12;
    step();
    chk("keybuf_rd12", rd_key, 128'h0);
`endif

    // Reset during round 6 abandons the expansion.
    do_start(FIPS_KEY);
    for (int r = 0; r < 6; r++) step();
    chk("pre_reset_round", 128'(rk_round), 128'(6));
    chk("pre_reset_rk", rk, fips_rk[6]);
    reset_n = 1'b0;
    #1;
    chk("midreset_valid", 128'(rk_valid), 128'(0));
    chk("midreset_rk", rk, 128'h0);
    chk("midreset_round", 128'(rk_round), 128'(0));
    chk("midreset_busy", 128'(busy), 128'(0));
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("post_reset_idle", 128'(rk_valid), 128'(0));
    do_start(128'h0);
    chk("post_reset_r0", rk, 128'h0);
    step();
    chk("post_reset_r1", rk, ZERO_R1);
    chk("post_reset_round1", 128'(rk_round), 128'(1));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 SHALL have parameter: NUM_ROUNDS, 10, number of round keys emitted after round key 0 (legal 1..10).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request new expansion, sampled only in IDLE.
REQ-005 SHALL have port: key  input  128  cipher key, key[127:96] = w0, sampled with start.
REQ-006 SHALL have port: rk_valid  output  1  round key on rk is valid.
REQ-007 SHALL have port: rk_ready  input  1  downstream (addRoundKey stage) accepts rk.
REQ-008 SHALL have port: rk  output  128  current round key, same byte/word order as the state bus.
REQ-009 SHALL have port: rk_round  output  4  index of round key on rk (0..NUM_ROUNDS).
REQ-010 SHALL have port: busy  output  1  high in EMIT state.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after last round key accepted.

Function
REQ-012 SHALL implement FSM with states IDLE and EMIT only.
REQ-013 IDLE with start=1 SHALL, at the next edge, load rk=key, rk_round=0, rcon=8'h01, rk_valid=1, and enter EMIT.
REQ-014 Handshake SHALL occur on a cycle with rk_valid & rk_ready; no other event advances the schedule.
REQ-015 While rk_valid=1 and rk_ready=0, rk and rk_round SHALL hold stable.
REQ-016 On handshake with rk_round<NUM_ROUNDS, next rk SHALL be registered one edge later: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w4=w0^t; w5=w1^w4; w6=w2^w5; w7=w3^w6; rk_round increments; rk_valid stays 1 (one key per cycle under continuous ready).
REQ-017 rcon SHALL advance by GF(2^8) multiply-by-x (left shift, XOR 8'h1B on bit-7 overflow) on each such handshake: 01,02,04,08,10,20,40,80,1B,36.
REQ-018 On handshake with rk_round==NUM_ROUNDS, FSM SHALL return to IDLE, clear rk_valid, and pulse done for exactly one cycle; rk holds last value.
REQ-019 start asserted in EMIT SHALL be ignored (no restart, no queuing).
REQ-020 start asserted in the cycle done is high SHALL be accepted (FSM already in IDLE).
REQ-021 busy SHALL equal (state==EMIT); rk_valid SHALL equal busy.

Reset
REQ-022 reset_n low SHALL asynchronously force: state IDLE, rk_valid 0, rk 128'h0, rk_round 0, rcon 8'h01, done 0, busy 0.
REQ-023 Reset asserted mid-expansion SHALL abandon it; after release the block waits for a new start.

Configuration
REQ-024 With macro KEY_SCHEDULE_KEYBUF_EN defined, SHALL add an 11x128 buffer written with each emitted rk at index rk_round, plus ports rd_idx input 4 and rd_key output 128 with registered 1-cycle read latency (rd_idx>10 returns 128'h0); buffer is not reset.
REQ-025 Without KEY_SCHEDULE_KEYBUF_EN, SHALL have no buffer and no rd_idx/rd_key ports.

Structure
REQ-026 SHALL place in shared package aes_pkg: state enum typedef, RCON_INIT (8'h01), GF_POLY (8'h1B), MAX_ROUNDS (10).
REQ-027 SHALL use one sub-module subWord (32-bit combinational S-box substitution, four byte S-box lookups), instanced once.

Verification
REQ-028 key=2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 -> round 1 rk=a0fafe1788542cb123a339392a6c7605, round 10 rk=d014f9a8c9ee2589e13f0cc8b6630ca6, done pulse at the edge the round-10 handshake completes, 11 consecutive valid cycles.
REQ-029 key=0, rk_ready=1 -> round 1 rk=62636363626363636263636362636363.
REQ-030 FIPS key, rk_ready toggled 1/0 pseudo-randomly -> rk stable during stalls, same 11 keys in order, rcon sequence ends 1B,36.
REQ-031 start pulsed at round 4 of an expansion -> ignored, schedule continues unchanged to round 10.
REQ-032 reset_n low during round 6 -> rk_valid=0, rk=0 immediately; new start with zero key -> round 1 = 62636363...62636363.
REQ-033 KEY_SCHEDULE_KEYBUF_EN defined, FIPS key expansion complete, rd_idx=10 -> rd_key=d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later; rd_idx=12 -> 128'h0.
